inst_encoder: RTL and testbench
===============================

// Module: inst_encoder
// PURPOSE
//  Inverse of the decode path: packs RV32I instruction descriptors (op class, regs, funct3, alt, imm) into 32-bit words.
//  Feeds the IMEM program-loader / self-test generator: encoded words leave through a valid/ready port with an IMEM word address.
//  Runs a bounded job: start loads base address and count; done asserts after that many words are accepted downstream.
// PARAMETERS
//  ADDR_WIDTH  14          IMEM byte-address width; out_addr wraps modulo 2^ADDR_WIDTH
//  CNT_WIDTH   12          width of job length / error counters
// PORTS
//  clk          in   1           clock, rising edge
//  rst_n        in   1           asynchronous active-low reset
//  start        in   1           pulse: begin job (honoured only in IDLE or DONE)
//  base_addr    in   ADDR_WIDTH  first out_addr of job (bits[1:0] forced 0)
//  job_len      in   CNT_WIDTH   words in job; 0 -> straight to DONE
//  in_valid     in   1           descriptor valid
//  in_ready     out  1           descriptor accepted when in_valid&in_ready
//  in_class     in   4           0 R,1 I-ALU,2 LOAD,3 STORE,4 BRANCH,5 JAL,6 JALR,7 LUI,8 AUIPC; 9-15 illegal
//  in_rd/in_rs1/in_rs2 in 5 each register indices
//  in_funct3    in   3           funct3 (ignored for JAL/LUI/AUIPC; JALR requires 000)
//  in_alt       in   1           sets inst[30] (SUB/SRA/SRAI); legal only R add/srl and I srli
//  in_imm       in   32          signed byte offset / immediate; U-type gives full value
//  out_valid    out  1           encoded word valid
//  out_ready    in   1           downstream (IMEM writer) accepts
//  out_inst     out  32          encoded instruction
//  out_addr     out  ADDR_WIDTH  byte address for out_inst
//  busy / done  out  1 each      state RUN / state DONE
//  err_sticky   out  1           any illegal descriptor since start
//  err_count    out  CNT_WIDTH   illegal descriptors since start (saturating)
// BEHAVIOUR
//  Reset: state IDLE; in_ready, out_valid, busy, done, err_sticky=0; out_inst=0; out_addr=0; err_count=0; counters 0.
//  FSM: IDLE -start-> RUN (job_len!=0) or DONE (job_len==0). RUN -> DONE on acceptance of last word. DONE -start-> as IDLE.
//   start in RUN ignored. start clears err_sticky/err_count, loads out_addr=base_addr, remaining=job_len.
//  in_ready = (state==RUN) && (issued<job_len) && (!out_valid || out_ready). No descriptors accepted in IDLE/DONE.
//  Latency: 1 cycle; word on out_inst/out_valid the cycle after acceptance; full throughput 1 word/cycle.
//  out_valid holds with out_inst/out_addr stable until out_ready; out_addr += 4 on each accepted output (wraps).
//  Encoding (opcodes): R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111,
//   LUI 0110111, AUIPC 0010111. Standard RV32I field placement; R: inst[31:25]={1'b0,alt,5'b0};
//   I shifts (f3 001/101): inst[31:25]={1'b0,alt,5'b0}, inst[24:20]=imm[4:0]; B/J scramble per ISA, imm[0] dropped.
//  Legality (else illegal): I/LOAD/STORE/JALR imm in [-2048,2047]; B imm in [-4096,4094] and even;
//   J imm in [-2^20,2^20-2] and even; U imm[11:0]==0; shift imm in [0,31]; LOAD f3 in {0,1,2,4,5};
//   STORE f3<=2; BRANCH f3 not 2/3; alt only where listed; class 9-15.
//  Illegal descriptor: still consumes a slot, emits NOP 0x00000013 at its address, err_sticky=1, err_count++ (saturate).
//  rd/rs fields encoded verbatim (x0 destination is legal).
//  Simultaneous output accept + new input accept: register reloads same cycle, no bubble.
//  Reset mid-job: all state cleared immediately (async); pending word dropped.
// TESTING
//  job_len=3 base=0x100: addi x1,x0,5; add x3,x1,x2; sub x3,x1,x2 -> 0x00500093@0x100,0x002081B3@0x104,0x402081B3@0x108, done.
//  sw x2,8(x1); beq x1,x2,+8; jal x1,+16; lui x5,0x12345000 -> 0x0020A423, 0x00208463, 0x010000EF, 0x123452B7.
//  beq imm=+5 (odd) and addi imm=2048 -> both emit 0x00000013, err_count=2, err_sticky=1; next start clears both.
//  out_ready held low 5 cycles with in_valid high -> out_inst stable, in_ready=0, no descriptor lost or duplicated.
//  base=0x3FFC (ADDR_WIDTH=14), job_len=2 -> addrs 0x3FFC then 0x0000; job_len=0 -> DONE next cycle, no out_valid.
//  rst_n low while out_valid=1 mid-job -> all outputs 0 asynchronously; fresh start re-runs job correctly.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32I instruction descriptors into 32-bit words for the
// IMEM program loader. A job (start/base_addr/job_len) emits job_len words on
// a valid/ready port, each tagged with its IMEM byte address.
// Illegal descriptors emit a NOP and are counted in err_count/err_sticky.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, base_addr, job_len  job launch (honoured in IDLE/DONE)
//   in_valid/in_ready          descriptor handshake
//   in_class, in_rd, in_rs1, in_rs2, in_funct3, in_alt, in_imm  descriptor
//   out_valid/out_ready        encoded word handshake
//   out_inst, out_addr         encoded word and its byte address
//   busy, done                 job running / job finished
//   err_sticky, err_count      illegal-descriptor flag and saturating count
module inst_encoder #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned CNT_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  job_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_class,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic                  in_alt,
  input  logic [31:0]           in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_inst,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err_sticky,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] CL_R      = 4'd0;
  localparam logic [3:0] CL_I      = 4'd1;
  localparam logic [3:0] CL_LOAD   = 4'd2;
  localparam logic [3:0] CL_STORE  = 4'd3;
  localparam logic [3:0] CL_BRANCH = 4'd4;
  localparam logic [3:0] CL_JAL    = 4'd5;
  localparam logic [3:0] CL_JALR   = 4'd6;
  localparam logic [3:0] CL_LUI    = 4'd7;
  localparam logic [3:0] CL_AUIPC  = 4'd8;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic [1:0]            state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_inst_q, out_inst_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0]  issued_q, issued_d;
  logic [CNT_WIDTH-1:0]  job_len_q, job_len_d;
  logic                  err_sticky_q, err_sticky_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;

  logic        enc_illegal;
  logic [31:0] enc_inst;
  logic        fits_i, fits_b, fits_j, fits_sh, is_shift;

  // Immediate range checks: a value fits N signed bits when its upper bits are all-0 or all-1
  assign fits_i   = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign fits_b   = ((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) && !in_imm[0];
  assign fits_j   = ((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) && !in_imm[0];
  assign fits_sh  = (in_imm[31:5] == '0);
  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  // Descriptor -> instruction word; illegal descriptors collapse to NOP
  always_comb begin
    enc_illegal = 1'b0;
    enc_inst    = '0;
    case (in_class)
      CL_R: begin
        enc_illegal = in_alt && !((in_funct3 == 3'b000) || (in_funct3 == 3'b101));
        enc_inst    = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      end
      CL_I: begin
        if (is_shift) begin
          enc_illegal = !fits_sh || (in_alt && (in_funct3 != 3'b101));
          enc_inst    = {1'b0, in_alt, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_I};
        end else begin
          enc_illegal = !fits_i || in_alt;
          enc_inst    = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
        end
      end
      CL_LOAD: begin
        enc_illegal = !fits_i || in_alt || (in_funct3 == 3'b011) || (in_funct3 == 3'b110) ||
                      (in_funct3 == 3'b111);
        enc_inst    = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      end
      CL_STORE: begin
        enc_illegal = !fits_i || in_alt || (in_funct3 > 3'd2);
        enc_inst    = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
      end
      CL_BRANCH: begin
        enc_illegal = !fits_b || in_alt || (in_funct3 == 3'b010) || (in_funct3 == 3'b011);
        enc_inst    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], OP_BRANCH};
      end
      CL_JAL: begin
        enc_illegal = !fits_j || in_alt;
        enc_inst    = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
      end
      CL_JALR: begin
        enc_illegal = !fits_i || in_alt || (in_funct3 != 3'b000);
        enc_inst    = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
      end
      CL_LUI: begin
        enc_illegal = (in_imm[11:0] != '0) || in_alt;
        enc_inst    = {in_imm[31:12], in_rd, OP_LUI};
      end
      CL_AUIPC: begin
        enc_illegal = (in_imm[11:0] != '0) || in_alt;
        enc_inst    = {in_imm[31:12], in_rd, OP_AUIPC};
      end
      default: enc_illegal = 1'b1;
    endcase
    if (enc_illegal) enc_inst = NOP_INST;
  end

  // Accept a descriptor only when the output register is free or draining this cycle
  assign in_ready = (state_q == ST_RUN) && (issued_q < job_len_q) && (!out_valid_q || out_ready);

  // Job sequencing, output register load/drain and error accounting
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_inst_d   = out_inst_q;
    out_addr_d   = out_addr_q;
    remaining_d  = remaining_q;
    issued_d     = issued_q;
    job_len_d    = job_len_q;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          out_valid_d  = 1'b0;
          out_addr_d   = {base_addr[ADDR_WIDTH-1:2], 2'b00};
          remaining_d  = job_len;
          job_len_d    = job_len;
          issued_d     = '0;
          err_sticky_d = 1'b0;
          err_count_d  = '0;
          state_d      = (job_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_addr_d  = ADDR_WIDTH'(out_addr_q + ADDR_WIDTH'(4));
          remaining_d = CNT_WIDTH'(remaining_q - CNT_WIDTH'(1));
          if (remaining_q == CNT_WIDTH'(1)) state_d = ST_DONE;
        end
        // Same-cycle reload after a drain keeps throughput at one word per cycle
        if (in_valid && in_ready) begin
          out_valid_d = 1'b1;
          out_inst_d  = enc_inst;
          issued_d    = CNT_WIDTH'(issued_q + CNT_WIDTH'(1));
          if (enc_illegal) begin
            err_sticky_d = 1'b1;
            if (err_count_q != '1) err_count_d = CNT_WIDTH'(err_count_q + CNT_WIDTH'(1));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      out_inst_q   <= '0;
      out_addr_q   <= '0;
      remaining_q  <= '0;
      issued_q     <= '0;
      job_len_q    <= '0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_inst_q   <= out_inst_d;
      out_addr_q   <= out_addr_d;
      remaining_q  <= remaining_d;
      issued_q     <= issued_d;
      job_len_q    <= job_len_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_inst   = out_inst_q;
  assign out_addr   = out_addr_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Testbench for inst_encoder: directed descriptor jobs checked against a
// bench-side RV32I encoding model, with an output scoreboard on every cycle.
module tb_inst_encoder;

  localparam int unsigned AW = 14;
  localparam int unsigned CW = 12;

  typedef struct packed {
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] imm;
  } desc_t;

  logic          clk, rst_n, start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] job_len;
  logic          in_valid, in_ready;
  logic [3:0]    in_class;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic          in_alt;
  logic [31:0]   in_imm;
  logic          out_valid, out_ready;
  logic [31:0]   out_inst;
  logic [AW-1:0] out_addr;
  logic          busy, done, err_sticky;
  logic [CW-1:0] err_count;

  inst_encoder #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .job_len(job_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_alt(in_alt),
    .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .busy(busy), .done(done), .err_sticky(err_sticky),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  desc_t       desc_q[$];
  logic [31:0] exp_q[$];
  logic [AW-1:0] exp_addr;
  int          idx;
  int          exp_err;
  int          n_seen;
  logic [AW-1:0] seen_addr [8];
  logic        mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic desc_t mk(input int cls, input int rd, input int rs1, input int rs2,
                               input int f3, input int alt, input int imm);
    desc_t d;
    d.cls = 4'(cls); d.rd = 5'(rd); d.rs1 = 5'(rs1); d.rs2 = 5'(rs2);
    d.f3 = 3'(f3); d.alt = 1'(alt); d.imm = 32'(imm);
    return d;
  endfunction

  // Reference encoder: {illegal, word} built from the ISA field rules with integer arithmetic
  function automatic logic [32:0] enc_model(input desc_t d);
    int          v;
    logic [31:0] u, w, regs_rs, f3s;
    bit          ok;
    v   = int'($signed(d.imm));
    u   = d.imm;
    ok  = 1'b1;
    w   = 32'h0;
    regs_rs = (32'(d.rs2) << 20) | (32'(d.rs1) << 15);
    f3s = 32'(d.f3) << 12;
    case (int'(d.cls))
      0: begin
        ok = !d.alt || d.f3 == 0 || d.f3 == 5;
        w  = (32'(d.alt) << 30) | regs_rs | f3s | (32'(d.rd) << 7) | 32'h33;
      end
      1: begin
        if (d.f3 == 1 || d.f3 == 5) begin
          ok = v >= 0 && v <= 31 && (!d.alt || d.f3 == 5);
          w  = (32'(d.alt) << 30) | ((u & 32'h1F) << 20) | (32'(d.rs1) << 15) | f3s |
               (32'(d.rd) << 7) | 32'h13;
        end else begin
          ok = v >= -2048 && v <= 2047 && !d.alt;
          w  = ((u & 32'hFFF) << 20) | (32'(d.rs1) << 15) | f3s | (32'(d.rd) << 7) | 32'h13;
        end
      end
      2: begin
        ok = v >= -2048 && v <= 2047 && !d.alt && d.f3 != 3 && d.f3 < 6;
        w  = ((u & 32'hFFF) << 20) | (32'(d.rs1) << 15) | f3s | (32'(d.rd) << 7) | 32'h03;
      end
      3: begin
        ok = v >= -2048 && v <= 2047 && !d.alt && d.f3 <= 2;
        w  = (((u >> 5) & 32'h7F) << 25) | regs_rs | f3s | ((u & 32'h1F) << 7) | 32'h23;
      end
      4: begin
        ok = v >= -4096 && v <= 4094 && (v % 2 == 0) && !d.alt && d.f3 != 2 && d.f3 != 3;
        w  = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | regs_rs | f3s |
             (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
      end
      5: begin
        ok = v >= -1048576 && v <= 1048574 && (v % 2 == 0) && !d.alt;
        w  = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20) |
             (((u >> 12) & 32'hFF) << 12) | (32'(d.rd) << 7) | 32'h6F;
      end
      6: begin
        ok = v >= -2048 && v <= 2047 && !d.alt && d.f3 == 0;
        w  = ((u & 32'hFFF) << 20) | (32'(d.rs1) << 15) | (32'(d.rd) << 7) | 32'h67;
      end
      7, 8: begin
        ok = (u % 4096 == 0) && !d.alt;
        w  = (u & 32'hFFFFF000) | (32'(d.rd) << 7) | ((d.cls == 7) ? 32'h37 : 32'h17);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) w = 32'h00000013;
    return {!ok, w};
  endfunction

  // Scoreboard: every cycle with out_valid the word must match the oldest expected entry
  always @(negedge clk) begin
    logic [32:0] m;
    if (mon_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out_valid", 32'(out_valid), 32'd0);
        else begin
          chk("out_inst", out_inst, exp_q[0]);
          chk("out_addr", 32'(out_addr), 32'(exp_addr));
          if (!out_ready) chk("in_ready_during_stall", 32'(in_ready), 32'd0);
          else begin
            if (n_seen < 8) seen_addr[n_seen] = out_addr;
            n_seen++;
            void'(exp_q.pop_front());
            exp_addr = AW'(exp_addr + AW'(4));
          end
        end
      end
      if (in_valid && in_ready) begin
        m = enc_model(desc_q[idx]);
        exp_q.push_back(m[31:0]);
        if (m[32]) exp_err++;
        idx++;
      end
    end
  end

  task automatic run_job(input logic [AW-1:0] base, input int len, input bit stall);
    int c;
    exp_q.delete();
    idx = 0; exp_err = 0; n_seen = 0;
    exp_addr = {base[AW-1:2], 2'b00};
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; job_len = CW'(len); mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(len != 0));
    chk("done_after_start", 32'(done), 32'(len == 0));
    chk("err_count_cleared", 32'(err_count), 32'd0);
    c = 0;
    while (!done && c < 300) begin
      in_valid = idx < desc_q.size();
      if (in_valid) begin
        in_class = desc_q[idx].cls; in_rd = desc_q[idx].rd; in_rs1 = desc_q[idx].rs1;
        in_rs2 = desc_q[idx].rs2; in_funct3 = desc_q[idx].f3; in_alt = desc_q[idx].alt;
        in_imm = desc_q[idx].imm;
      end
      out_ready = !(stall && c >= 2 && c < 7);
      @(posedge clk); #1;
      c++;
    end
    if (!done) chk("job_timeout", 32'(done), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    chk("all_words_issued", 32'(idx), 32'(len));
    chk("no_words_left", 32'(exp_q.size()), 32'd0);
    chk("done_at_end", 32'(done), 32'd1);
    chk("busy_at_end", 32'(busy), 32'd0);
    chk("err_count", 32'(err_count), 32'(exp_err));
    chk("err_sticky", 32'(err_sticky), 32'(exp_err != 0));
  endtask

  task automatic load_basic();
    desc_q.delete();
    desc_q.push_back(mk(1, 1, 0, 0, 0, 0, 5));
    desc_q.push_back(mk(0, 3, 1, 2, 0, 0, 0));
    desc_q.push_back(mk(0, 3, 1, 2, 0, 1, 0));
  endtask

  initial begin
    logic [32:0] m;
    int          t;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; job_len = '0; in_valid = 1'b0;
    in_class = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_alt = 1'b0;
    in_imm = '0; out_ready = 1'b1;

    // Model pinned against hand-encoded words
    m = enc_model(mk(1, 1, 0, 0, 0, 0, 5));        chk("lit_addi", m[31:0], 32'h00500093);
    m = enc_model(mk(0, 3, 1, 2, 0, 0, 0));        chk("lit_add", m[31:0], 32'h002081B3);
    m = enc_model(mk(0, 3, 1, 2, 0, 1, 0));        chk("lit_sub", m[31:0], 32'h402081B3);
    m = enc_model(mk(3, 0, 1, 2, 2, 0, 8));        chk("lit_sw", m[31:0], 32'h0020A423);
    m = enc_model(mk(4, 0, 1, 2, 0, 0, 8));        chk("lit_beq", m[31:0], 32'h00208463);
    m = enc_model(mk(5, 1, 0, 0, 0, 0, 16));       chk("lit_jal", m[31:0], 32'h010000EF);
    m = enc_model(mk(7, 5, 0, 0, 0, 0, 32'h12345000)); chk("lit_lui", m[31:0], 32'h123452B7);
    m = enc_model(mk(1, 4, 4, 0, 5, 1, 3));        chk("lit_srai", m[31:0], 32'h40325213);
    m = enc_model(mk(4, 0, 1, 2, 0, 0, 5));        chk("lit_beq_odd", m, 33'h100000013);
    m = enc_model(mk(1, 1, 0, 0, 0, 0, 2048));     chk("lit_addi_big", m, 33'h100000013);

    // Reset values
    #12;
    chk("rst_out_valid", 32'(out_valid), 0); chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);           chk("rst_done", 32'(done), 0);
    chk("rst_err_sticky", 32'(err_sticky), 0); chk("rst_err_count", 32'(err_count), 0);
    chk("rst_out_inst", out_inst, 0);        chk("rst_out_addr", 32'(out_addr), 0);
    #10 rst_n = 1'b1;

    // Basic ALU job
    load_basic();
    run_job(AW'(14'h100), 3, 1'b0);
    chk("basic_addr0", 32'(seen_addr[0]), 32'h100);
    chk("basic_addr2", 32'(seen_addr[2]), 32'h108);

    // Store/branch/jump/upper, then stall with backpressure
    desc_q.delete();
    desc_q.push_back(mk(3, 0, 1, 2, 2, 0, 8));
    desc_q.push_back(mk(4, 0, 1, 2, 0, 0, 8));
    desc_q.push_back(mk(5, 1, 0, 0, 0, 0, 16));
    desc_q.push_back(mk(7, 5, 0, 0, 0, 0, 32'h12345000));
    desc_q.push_back(mk(1, 4, 4, 0, 5, 1, 3));
    desc_q.push_back(mk(4, 0, 1, 2, 1, 0, -4));
    desc_q.push_back(mk(2, 7, 2, 0, 2, 0, -16));
    desc_q.push_back(mk(6, 0, 1, 0, 0, 0, 0));
    run_job(AW'(14'h200), 8, 1'b1);

    // Illegal descriptors
    desc_q.delete();
    desc_q.push_back(mk(4, 0, 1, 2, 0, 0, 5));
    desc_q.push_back(mk(1, 1, 0, 0, 0, 0, 2048));
    desc_q.push_back(mk(12, 1, 0, 0, 0, 0, 0));
    desc_q.push_back(mk(2, 1, 0, 0, 3, 0, 0));
    run_job(AW'(14'h040), 4, 1'b0);
    chk("err_count_lit", 32'(err_count), 32'd4);

    // Address wrap and zero-length job (start also clears errors)
    load_basic();
    run_job(AW'(14'h3FFC), 2, 1'b0);
    chk("wrap_addr0", 32'(seen_addr[0]), 32'h3FFC);
    chk("wrap_addr1", 32'(seen_addr[1]), 32'h0000);
    run_job(AW'(14'h080), 0, 1'b0);

    // Asynchronous reset mid-job with a word pending
    load_basic();
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(14'h100); job_len = CW'(3);
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_class = desc_q[0].cls; in_rd = desc_q[0].rd; in_rs1 = desc_q[0].rs1;
    in_rs2 = desc_q[0].rs2; in_funct3 = desc_q[0].f3; in_alt = desc_q[0].alt;
    in_imm = desc_q[0].imm;
    t = 0;
    while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0); chk("arst_busy", 32'(busy), 0);
    chk("arst_out_inst", out_inst, 0);        chk("arst_out_addr", 32'(out_addr), 0);
    chk("arst_in_ready", 32'(in_ready), 0);   chk("arst_done", 32'(done), 0);
    in_valid = 1'b0; out_ready = 1'b1;
    #10 rst_n = 1'b1;
    run_job(AW'(14'h100), 3, 1'b0);
    chk("rerun_addr1", 32'(seen_addr[1]), 32'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
